receive_framed: RTL and testbench

Parametrised UART receiver: the next-generation replacement for the fixed 8N1 `receive` block. It adds configurable data width, optional odd/even parity, one or two stop bits, and 16x (configurable) oversampling with majority-vote bit decisions. Per-word framing, parity and overrun flags travel with the word. It sits between the `rxd` pin and the same `stb`/`rdy` consumer interface used by `transmit` and downstream logic.

---
 rtl/receive_framed.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_receive_framed.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/receive_framed.sv
// receive_framed: parametrised UART receiver with oversampling, optional parity
// and one or two stop bits. Each received word is presented on a stb/rdy
// handshake together with its framing, parity and overrun flags.
//
// Ports
//   clk   sole clock
//   rst   synchronous, active-high reset
//   rxd   asynchronous serial line, idle high
//   rdy   consumer ready
//   stb   word valid
//   dat   received word (LSB first on the line)
//   ferr  a stop bit was sampled 0
//   perr  parity mismatch (always 0 without parity)
//   ovr   at least one earlier word was lost before this one
module receive_framed #(
  parameter real BAUDRATE   = 96e2,
  parameter real FREQUENCY  = 12e6,
  parameter int  OVERSAMPLE = 16,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdy,
  output logic                 stb,
  output logic [DATA_BITS-1:0] dat,
  output logic                 ferr,
  output logic                 perr,
  output logic                 ovr
);

  localparam int   DIVISOR    = $rtoi(FREQUENCY / (BAUDRATE * OVERSAMPLE));
  localparam int   M          = OVERSAMPLE / 2;
  localparam int   DIV_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int   TICK_W     = $clog2(OVERSAMPLE);
  localparam int   BIT_W      = $clog2(DATA_BITS);
  localparam logic HAS_PARITY = (PARITY != 0);
  localparam logic ODD_PARITY = (PARITY == 1);

  if (DIVISOR < 2) begin : g_divisor_check
    $error("receive_framed: DIVISOR must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Mismatch between the received parity bit and the one implied by the data.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 bit_v,
                                           input logic                 odd);
    return (^data) ^ bit_v ^ odd;
  endfunction

  logic                 rxd_meta_r;
  logic                 rxs_r;
  state_t               state_r;
  state_t               state_nxt_s;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic                 samp_a_r;
  logic                 samp_b_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 stop_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_acc_r;
  logic                 ferr_acc_r;
  logic                 stb_r;
  logic [DATA_BITS-1:0] dat_r;
  logic                 ferr_r;
  logic                 perr_r;
  logic                 ovr_r;

  logic                 tick_s;
  logic                 decide_s;
  logic                 maj_s;
  logic                 start_s;
  logic                 shift_s;
  logic                 par_chk_s;
  logic                 stop_s;
  logic                 load_s;
  logic                 ferr_new_s;

  // A tick is the last clock of each divider period.
  assign tick_s   = (div_cnt_r == DIV_W'(DIVISOR - 1));
  // The bit decision happens on tick M+1, i.e. while the counter still shows M.
  assign decide_s = tick_s && (tick_cnt_r == TICK_W'(M));
  // Majority of the samples taken on ticks M-1, M and the current one (M+1).
  assign maj_s    = (samp_a_r & samp_b_r) | (samp_a_r & rxs_r) | (samp_b_r & rxs_r);
  assign ferr_new_s = ferr_acc_r | ~maj_s;

  // Two-flop synchronizer for the asynchronous line, resetting to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxs_r      <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxs_r      <= rxd_meta_r;
    end
  end

  // Divider and per-bit tick counter, realigned to the detected start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= '0;
      tick_cnt_r <= '0;
    end else if (start_s) begin
      div_cnt_r  <= '0;
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r  <= '0;
      if (tick_cnt_r == TICK_W'(OVERSAMPLE - 1)) begin
        tick_cnt_r <= '0;
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Capture the two early samples feeding the majority vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      if (tick_s && (tick_cnt_r == TICK_W'(M - 2))) begin
        samp_a_r <= rxs_r;
      end
      if (tick_s && (tick_cnt_r == TICK_W'(M - 1))) begin
        samp_b_r <= rxs_r;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-decision control strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    shift_s     = 1'b0;
    par_chk_s   = 1'b0;
    stop_s      = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_nxt_s = ST_START;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s) begin
          // A high majority means the falling edge was only a glitch.
          if (maj_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_s = 1'b1;
          if (bit_cnt_r == BIT_W'(DATA_BITS - 1)) begin
            state_nxt_s = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (decide_s) begin
          par_chk_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          stop_s = 1'b1;
          if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
            // Leaving mid stop bit lets a back-to-back start edge be caught.
            load_s      = 1'b1;
            state_nxt_s = ferr_new_s ? ST_BREAK : ST_IDLE;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rxs_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Frame assembly: data shift register, bit/stop counters and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      perr_acc_r <= 1'b0;
      ferr_acc_r <= 1'b0;
    end else if (start_s) begin
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      perr_acc_r <= 1'b0;
      ferr_acc_r <= 1'b0;
    end else begin
      if (shift_s) begin
        shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (par_chk_s) begin
        perr_acc_r <= parity_mismatch(shift_r, maj_s, ODD_PARITY);
      end
      if (stop_s) begin
        ferr_acc_r <= ferr_new_s;
        stop_cnt_r <= stop_cnt_r + 1'b1;
      end
    end
  end

  // Output register; a newly completed word always replaces a pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_r  <= 1'b0;
      dat_r  <= '0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else if (load_s) begin
      stb_r  <= 1'b1;
      dat_r  <= shift_r;
      ferr_r <= ferr_new_s;
      perr_r <= perr_acc_r;
      ovr_r  <= stb_r && !rdy;
    end else if (stb_r && rdy) begin
      stb_r  <= 1'b0;
    end
  end

  assign stb  = stb_r;
  assign dat  = dat_r;
  assign ferr = ferr_r;
  assign perr = perr_r;
  assign ovr  = ovr_r;

endmodule

// File: tb/tb_receive_framed.sv
// Directed bench for receive_framed: one 8N1 instance and one 8E1 instance,
// each fed from the shared line driver through a selector.
module tb_receive_framed;

  localparam int BIT = 240;  // 16 ticks x 15 clocks at 12 MHz / 48 kbaud

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  logic       line = 1'b1;
  logic       use_par = 1'b0;
  logic       rxd_a;
  logic       rxd_b;

  logic       stb_a, ferr_a, perr_a, ovr_a;
  logic [7:0] dat_a;
  logic       stb_b, ferr_b, perr_b, ovr_b;
  logic [7:0] dat_b;

  int checks = 0;
  int errors = 0;

  int         rises_a = 0, hi_a = 0, rises_b = 0;
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] last_dat_a = 8'h00, last_dat_b = 8'h00;
  logic       last_ferr_a = 1'b0, last_perr_a = 1'b0, last_ovr_a = 1'b0;
  logic       last_ferr_b = 1'b0, last_perr_b = 1'b0;

  int base_r, base_h, base_b;

  assign rxd_a = use_par ? 1'b1 : line;
  assign rxd_b = use_par ? line : 1'b1;

  always #5 clk = ~clk;

  receive_framed #(
    .BAUDRATE(48e3), .FREQUENCY(12e6), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rdy(rdy),
    .stb(stb_a), .dat(dat_a), .ferr(ferr_a), .perr(perr_a), .ovr(ovr_a)
  );

  receive_framed #(
    .BAUDRATE(48e3), .FREQUENCY(12e6), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rdy(rdy),
    .stb(stb_b), .dat(dat_b), .ferr(ferr_b), .perr(perr_b), .ovr(ovr_b)
  );

  // Output monitor on the inactive edge: counts strobe pulses and keeps the last word.
  always @(negedge clk) begin
    if (stb_a) begin
      hi_a        = hi_a + 1;
      last_dat_a  = dat_a;
      last_ferr_a = ferr_a;
      last_perr_a = perr_a;
      last_ovr_a  = ovr_a;
      if (!prev_a) rises_a = rises_a + 1;
    end
    if (stb_b) begin
      last_dat_b  = dat_b;
      last_ferr_b = ferr_b;
      last_perr_b = perr_b;
      if (!prev_b) rises_b = rises_b + 1;
    end
    prev_a = stb_a;
    prev_b = stb_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    line = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_val);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("reset_stb",  32'(stb_a),  32'd0);
    check_eq("reset_dat",  32'(dat_a),  32'h0);
    check_eq("reset_ferr", 32'(ferr_a), 32'd0);
    check_eq("reset_perr", 32'(perr_a), 32'd0);
    check_eq("reset_ovr",  32'(ovr_a),  32'd0);
    idle_bits(1);

    // 8N1 clean word with rdy held high: single one-clock pulse
    base_r = rises_a; base_h = hi_a;
    send_frame(8'h8F, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("clean_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("clean_width",  32'(hi_a - base_h),    32'd1);
    check_eq("clean_dat",    32'(last_dat_a),       32'h8F);
    check_eq("clean_ferr",   32'(last_ferr_a),      32'd0);
    check_eq("clean_perr",   32'(last_perr_a),      32'd0);
    check_eq("clean_ovr",    32'(last_ovr_a),       32'd0);

    // Even parity: 0x8F has five ones, so the correct parity bit is 1
    use_par = 1'b1;
    base_b = rises_b;
    send_frame(8'h8F, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check_eq("par_ok_pulses", 32'(rises_b - base_b), 32'd1);
    check_eq("par_ok_dat",    32'(last_dat_b),       32'h8F);
    check_eq("par_ok_perr",   32'(last_perr_b),      32'd0);
    base_b = rises_b;
    send_frame(8'h8F, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("par_bad_pulses", 32'(rises_b - base_b), 32'd1);
    check_eq("par_bad_dat",    32'(last_dat_b),       32'h8F);
    check_eq("par_bad_perr",   32'(last_perr_b),      32'd1);
    check_eq("par_bad_ferr",   32'(last_ferr_b),      32'd0);
    use_par = 1'b0;

    // Framing error followed by a held-low line, then recovery
    base_r = rises_a;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check_eq("ferr_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("ferr_dat",    32'(last_dat_a),       32'h3C);
    check_eq("ferr_flag",   32'(last_ferr_a),      32'd1);
    idle_bits(1);
    base_r = rises_a;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("recover_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("recover_dat",    32'(last_dat_a),       32'h55);
    check_eq("recover_ferr",   32'(last_ferr_a),      32'd0);

    // Glitch of three ticks must not start a frame
    base_r = rises_a;
    line = 1'b0;
    repeat (45) @(negedge clk);
    idle_bits(2);
    check_eq("glitch_pulses", 32'(rises_a - base_r), 32'd0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("glitch_next_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("glitch_next_dat",    32'(last_dat_a),       32'hA5);

    // Overrun: two back-to-back words with rdy low
    rdy = 1'b0;
    base_r = rises_a;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("ovr_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("ovr_stb",    32'(stb_a),            32'd1);
    check_eq("ovr_dat",    32'(dat_a),            32'h22);
    check_eq("ovr_flag",   32'(ovr_a),            32'd1);
    check_eq("ovr_ferr",   32'(ferr_a),           32'd0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check_eq("ovr_accept_stb", 32'(stb_a), 32'd0);
    @(negedge clk);
    rdy = 1'b1;

    // Reset late in data bit 3 of 0xF0 (bits 0..3 are 0, 4..7 are 1)
    base_r = rises_a;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    line = 1'b0;
    repeat (BIT - 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_stb",  32'(stb_a),  32'd0);
    check_eq("rst_dat",  32'(dat_a),  32'h0);
    check_eq("rst_ovr",  32'(ovr_a),  32'd0);
    check_eq("rst_ferr", 32'(ferr_a), 32'd0);
    repeat (19) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(2);
    check_eq("rst_frame_pulses", 32'(rises_a - base_r), 32'd0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_eq("post_rst_pulses", 32'(rises_a - base_r), 32'd1);
    check_eq("post_rst_dat",    32'(last_dat_a),       32'hA5);
    check_eq("post_rst_ferr",   32'(last_ferr_a),      32'd0);
    check_eq("post_rst_perr",   32'(last_perr_a),      32'd0);
    check_eq("post_rst_ovr",    32'(last_ovr_a),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
